// File: rtl/spec_history_ckpt_if.sv
// rtl/spec_history_ckpt_if.sv - prediction/resolve/flush bus and history outputs for spec_history_ckpt
//
// Purpose: groups the handshake and history signals of spec_history_ckpt.
// Parameters must match those of the spec_history_ckpt instance it connects to.
//   master : front end / EX side (drives predictions, resolves, flush)
//   slave  : spec_history_ckpt (drives pred_ready, histories, counter, res_error)
// Signals:
//   pred_valid, pred_entry    - prediction made this cycle and entry to append
//   pred_ready                - room for another in-flight prediction
//   res_valid, res_mispredict - oldest in-flight branch resolves (and was mispredicted)
//   res_entry                 - true entry of the resolved branch
//   flush                     - discard all in-flight predictions
//   hist_spec, hist_commit    - speculative / committed histories, newest entry in MSBs
//   inflight_cnt              - unresolved predictions
//   res_error                 - one-cycle pulse on a resolve with nothing in flight

interface spec_history_ckpt_if #(
    parameter int W            = 10,
    parameter int DEPTH        = 16,
    parameter int MAX_INFLIGHT = 8
);
    localparam int HW = W * DEPTH;
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic          pred_valid;
    logic [W-1:0]  pred_entry;
    logic          pred_ready;
    logic          res_valid;
    logic          res_mispredict;
    logic [W-1:0]  res_entry;
    logic          flush;
    logic [HW-1:0] hist_spec;
    logic [HW-1:0] hist_commit;
    logic [CW-1:0] inflight_cnt;
    logic          res_error;

    modport master (
        output pred_valid,
        output pred_entry,
        input  pred_ready,
        output res_valid,
        output res_mispredict,
        output res_entry,
        output flush,
        input  hist_spec,
        input  hist_commit,
        input  inflight_cnt,
        input  res_error
    );

    modport slave (
        input  pred_valid,
        input  pred_entry,
        output pred_ready,
        input  res_valid,
        input  res_mispredict,
        input  res_entry,
        input  flush,
        output hist_spec,
        output hist_commit,
        output inflight_cnt,
        output res_error
    );
endinterface

// File: rtl/spec_history_ckpt.sv
// rtl/spec_history_ckpt.sv - speculative/committed history pair with in-flight tracking and repair
//
// Purpose: keeps a speculative history updated on every accepted prediction and
// a committed history updated only by in-order resolution. A mispredict or flush
// repairs the speculative history to the committed one (including the entry
// resolving in that same cycle). All state changes on the falling edge of clk.
// Ports:
//   clk - clock, state updates on the falling edge
//   rst - synchronous active-high reset, sampled on the falling edge
//   bus - spec_history_ckpt_if slave modport (see interface for signal list)
// Parameters: W (entry width), DEPTH (entries per history, >= 2),
//             MAX_INFLIGHT (max unresolved predictions, >= 1).

module spec_history_ckpt #(
    parameter int W            = 10,
    parameter int DEPTH        = 16,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    spec_history_ckpt_if.slave   bus
);
    localparam int HW = W * DEPTH;
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

    // Newest entry enters at the MSBs; the oldest entry (LSBs) falls off.
    function automatic logic [HW-1:0] shift_in(input logic [HW-1:0] h,
                                               input logic [W-1:0]  e);
        return {e, h[HW-1:W]};
    endfunction

    logic [HW-1:0] spec_q;
    logic [HW-1:0] commit_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;

    logic          ready;
    logic          pa;
    logic          rv;
    logic          repair;
    logic [HW-1:0] nc;

    // Ready depends only on the registered counter, so a resolve that frees a
    // slot in the same cycle cannot let a prediction through while full.
    assign ready  = (cnt_q != CNT_MAX);
    assign pa     = bus.pred_valid && ready;
    // A resolve with nothing in flight is ignored for the histories and counter.
    assign rv     = bus.res_valid && (cnt_q != '0);
    assign repair = bus.flush || (rv && bus.res_mispredict);
    // Committed history after this cycle's resolve; also the repair target so
    // the entry resolving alongside a mispredict/flush is not lost.
    assign nc     = rv ? shift_in(commit_q, bus.res_entry) : commit_q;

    always_ff @(negedge clk) begin
        if (rst) begin
            spec_q   <= '0;
            commit_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q    <= bus.res_valid && (cnt_q == '0);
            commit_q <= nc;
            if (repair) begin
                // Any prediction accepted this cycle is wrong-path and dropped.
                spec_q <= nc;
                cnt_q  <= '0;
            end else begin
                if (pa) begin
                    spec_q <= shift_in(spec_q, bus.pred_entry);
                end
                cnt_q <= cnt_q + CW'(pa) - CW'(rv);
            end
        end
    end

    assign bus.pred_ready   = ready;
    assign bus.hist_spec    = spec_q;
    assign bus.hist_commit  = commit_q;
    assign bus.inflight_cnt = cnt_q;
    assign bus.res_error    = err_q;

endmodule

// File: tb/tb_spec_history_ckpt.sv
// tb/tb_spec_history_ckpt.sv - directed table-driven bench for spec_history_ckpt

module tb_spec_history_ckpt;
    localparam int W  = 10;
    localparam int D  = 16;
    localparam int MI = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spec_history_ckpt_if #(.W(W), .DEPTH(D), .MAX_INFLIGHT(MI)) bus ();
    spec_history_ckpt #(.W(W), .DEPTH(D), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    spec_history_ckpt_if #(.W(1), .DEPTH(4), .MAX_INFLIGHT(1)) bus_s ();
    spec_history_ckpt #(.W(1), .DEPTH(4), .MAX_INFLIGHT(1)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s.slave)
    );

    typedef struct {
        logic         rs;
        logic         pv;
        logic [9:0]   pe;
        logic         rv;
        logic         rm;
        logic [9:0]   re;
        logic         fl;
        logic [159:0] es;
        logic [159:0] ec;
        logic [3:0]   en;
        logic         erdy;
        logic         eerr;
    } vec_t;

    vec_t v[$];
    int checks = 0;
    int errors = 0;

    function automatic void add(input logic rs, input logic pv, input logic [9:0] pe,
                                input logic rvv, input logic rm, input logic [9:0] re,
                                input logic fl, input logic [159:0] es, input logic [159:0] ec,
                                input logic [3:0] en, input logic erdy, input logic eerr);
        vec_t t;
        t.rs = rs; t.pv = pv; t.pe = pe; t.rv = rvv; t.rm = rm; t.re = re; t.fl = fl;
        t.es = es; t.ec = ec; t.en = en; t.erdy = erdy; t.eerr = eerr;
        v.push_back(t);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [159:0] act,
                       input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    logic [159:0] s3, f8, f9, c4, c5;
    logic         sb [5];
    logic [3:0]   sc [5];

    initial begin
        rst = 1'b1;
        bus.pred_valid = 0; bus.pred_entry = '0; bus.res_valid = 0;
        bus.res_mispredict = 0; bus.res_entry = '0; bus.flush = 0;
        bus_s.pred_valid = 0; bus_s.pred_entry = '0; bus_s.res_valid = 0;
        bus_s.res_mispredict = 0; bus_s.res_entry = '0; bus_s.flush = 0;

        s3 = {10'h2FF, 10'h055, 10'h3A1, 130'd0};
        f8 = {10'h108, 10'h107, 10'h106, 10'h105, 10'h104, 10'h103, 10'h102, 10'h101, 80'd0};
        f9 = {10'h109, 10'h108, 10'h107, 10'h106, 10'h105, 10'h104, 10'h103, 10'h102, 10'h101, 70'd0};
        c4 = {10'h104, 10'h103, 10'h102, 10'h101, 120'd0};
        c5 = {10'h0AB, 10'h104, 10'h103, 10'h102, 10'h101, 110'd0};

        // reset held for two edges
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // predict then correct resolve
        add(0, 1, 10'h3A1, 0, 0, 0, 0, {10'h3A1, 150'd0}, 0, 1, 1, 0);
        add(0, 1, 10'h055, 0, 0, 0, 0, {10'h055, 10'h3A1, 140'd0}, 0, 2, 1, 0);
        add(0, 1, 10'h2FF, 0, 0, 0, 0, s3, 0, 3, 1, 0);
        add(0, 0, 0, 1, 0, 10'h3A1, 0, s3, {10'h3A1, 150'd0}, 2, 1, 0);
        add(0, 0, 0, 1, 0, 10'h055, 0, s3, {10'h055, 10'h3A1, 140'd0}, 1, 1, 0);
        // mispredict with concurrent prediction
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 10'h001, 0, 0, 0, 0, {10'h001, 150'd0}, 0, 1, 1, 0);
        add(0, 1, 10'h002, 0, 0, 0, 0, {10'h002, 10'h001, 140'd0}, 0, 2, 1, 0);
        add(0, 1, 10'h003, 0, 0, 0, 0, {10'h003, 10'h002, 10'h001, 130'd0}, 0, 3, 1, 0);
        add(0, 1, 10'h222, 1, 1, 10'h111, 0, {10'h111, 150'd0}, {10'h111, 150'd0}, 0, 1, 0);
        add(0, 1, 10'h044, 0, 0, 0, 0, {10'h044, 10'h111, 140'd0}, {10'h111, 150'd0}, 1, 1, 0);
        // full
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 10'h101, 0, 0, 0, 0, {10'h101, 150'd0}, 0, 1, 1, 0);
        add(0, 1, 10'h102, 0, 0, 0, 0, {10'h102, 10'h101, 140'd0}, 0, 2, 1, 0);
        add(0, 1, 10'h103, 0, 0, 0, 0, {10'h103, 10'h102, 10'h101, 130'd0}, 0, 3, 1, 0);
        add(0, 1, 10'h104, 0, 0, 0, 0, {10'h104, 10'h103, 10'h102, 10'h101, 120'd0}, 0, 4, 1, 0);
        add(0, 1, 10'h105, 0, 0, 0, 0, {10'h105, 10'h104, 10'h103, 10'h102, 10'h101, 110'd0}, 0, 5, 1, 0);
        add(0, 1, 10'h106, 0, 0, 0, 0, {10'h106, 10'h105, 10'h104, 10'h103, 10'h102, 10'h101, 100'd0}, 0, 6, 1, 0);
        add(0, 1, 10'h107, 0, 0, 0, 0, {10'h107, 10'h106, 10'h105, 10'h104, 10'h103, 10'h102, 10'h101, 90'd0}, 0, 7, 1, 0);
        add(0, 1, 10'h108, 0, 0, 0, 0, f8, 0, 8, 0, 0);
        add(0, 1, 10'h1FF, 1, 0, 10'h101, 0, f8, {10'h101, 150'd0}, 7, 1, 0);
        add(0, 1, 10'h109, 0, 0, 0, 0, f9, {10'h101, 150'd0}, 8, 0, 0);
        add(0, 0, 0, 1, 0, 10'h102, 0, f9, {10'h102, 10'h101, 140'd0}, 7, 1, 0);
        add(0, 0, 0, 1, 0, 10'h103, 0, f9, {10'h103, 10'h102, 10'h101, 130'd0}, 6, 1, 0);
        add(0, 0, 0, 1, 0, 10'h104, 0, f9, c4, 5, 1, 0);
        // flush alone, then flush with a correct resolve
        add(0, 0, 0, 0, 0, 0, 1, c4, c4, 0, 1, 0);
        add(0, 1, 10'h2AA, 0, 0, 0, 0, {10'h2AA, 10'h104, 10'h103, 10'h102, 10'h101, 110'd0}, c4, 1, 1, 0);
        add(0, 0, 0, 1, 0, 10'h0AB, 1, c5, c5, 0, 1, 0);
        // illegal resolve pulses res_error once
        add(0, 0, 0, 1, 0, 10'h3FF, 0, c5, c5, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, c5, c5, 0, 1, 0);
        // res_mispredict without res_valid has no effect
        add(0, 1, 10'h00F, 0, 1, 10'h3FF, 0, {10'h00F, 10'h0AB, 10'h104, 10'h103, 10'h102, 10'h101, 100'd0}, c5, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, c5, c5, 0, 1, 0);
        // illegal resolve with flush still repairs, commit unchanged
        add(0, 1, 10'h3CC, 1, 0, 10'h3FF, 1, c5, c5, 0, 1, 1);

        for (int i = 0; i < v.size(); i++) begin
            rst                = v[i].rs;
            bus.pred_valid     = v[i].pv;
            bus.pred_entry     = v[i].pe;
            bus.res_valid      = v[i].rv;
            bus.res_mispredict = v[i].rm;
            bus.res_entry      = v[i].re;
            bus.flush          = v[i].fl;
            @(negedge clk);
            #1;
            chk("hist_spec", i, bus.hist_spec, v[i].es);
            chk("hist_commit", i, bus.hist_commit, v[i].ec);
            chk("inflight_cnt", i, 160'(bus.inflight_cnt), 160'(v[i].en));
            chk("pred_ready", i, 160'(bus.pred_ready), 160'(v[i].erdy));
            chk("res_error", i, 160'(bus.res_error), 160'(v[i].eerr));
        end

        // W=1, DEPTH=4, MAX_INFLIGHT=1: oldest outcome bit is shifted out
        bus.pred_valid = 0; bus.res_valid = 0; bus.res_mispredict = 0; bus.flush = 0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        chk("small_reset_commit", 100, 160'(bus_s.hist_commit), 160'd0);
        sb = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        sc = '{4'b1000, 4'b0100, 4'b1010, 4'b1101, 4'b0110};
        for (int k = 0; k < 5; k++) begin
            bus_s.pred_valid = 1'b1;
            bus_s.pred_entry = sb[k];
            bus_s.res_valid  = 1'b0;
            @(negedge clk);
            #1;
            chk("small_ready_full", 110 + k, 160'(bus_s.pred_ready), 160'd0);
            chk("small_cnt_one", 110 + k, 160'(bus_s.inflight_cnt), 160'd1);
            bus_s.pred_valid = 1'b0;
            bus_s.res_valid  = 1'b1;
            bus_s.res_entry  = sb[k];
            @(negedge clk);
            #1;
            chk("small_commit", 120 + k, 160'(bus_s.hist_commit), 160'(sc[k]));
            chk("small_spec", 120 + k, 160'(bus_s.hist_spec), 160'(sc[k]));
        end
        bus_s.res_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
